// File: rtl/block_memory_storage_if.sv
// Write (address-counter) and read buses of the per-SSID hit store.
// master = producer/reader side, slave = block_memory_storage.
interface block_memory_storage_if #(
   parameter int SSIDBITS  = 10,
   parameter int NCOLS_HIM = 32,
   parameter int MAXHITS   = 8,
   parameter int CNTBITS   = $clog2(MAXHITS) + 1
) ();
   localparam int IDXBITS = $clog2(MAXHITS);

   logic                 newAddress;
   logic [SSIDBITS-1:0]  SSID;
   logic [NCOLS_HIM-1:0] hitInfo;
   logic                 storageReady;
   logic                 readRequest;
   logic [SSIDBITS-1:0]  readSSID;
   logic [IDXBITS-1:0]   readIndex;
   logic                 readReady;
   logic                 readValid;
   logic [NCOLS_HIM-1:0] readData;
   logic [CNTBITS-1:0]   readCount;
   logic                 overflow;

   modport master (
      output newAddress, SSID, hitInfo, readRequest, readSSID, readIndex,
      input  storageReady, readReady, readValid, readData, readCount, overflow
   );

   modport slave (
      input  newAddress, SSID, hitInfo, readRequest, readSSID, readIndex,
      output storageReady, readReady, readValid, readData, readCount, overflow
   );
endinterface

// File: rtl/block_memory_storage.sv
// Per-SSID hit store: up to MAXHITS words per SSID in block RAM, counts swept to zero after reset.
// Optional DROP_COUNTER_EN adds a saturating 16-bit droppedHits counter.
module block_memory_storage #(
   parameter int SSIDBITS  = 10,
   parameter int NCOLS_HIM = 32,
   parameter int MAXHITS   = 8,
   parameter int CNTBITS   = $clog2(MAXHITS) + 1
) (
   input  logic clock,
   input  logic clearMemory,
   block_memory_storage_if.slave bus
`ifdef DROP_COUNTER_EN
   ,
   output logic [15:0] droppedHits
`endif
);
   localparam int IDXBITS  = $clog2(MAXHITS);
   localparam int NSSID    = 1 << SSIDBITS;
   localparam int ADDRBITS = SSIDBITS + IDXBITS;

   typedef enum logic {CLEAR, READY} state_t;

   state_t              stateReg, stateNext;
   logic [SSIDBITS:0]   sweepReg, sweepNext;
   logic                isReady;

   logic [CNTBITS-1:0]   countMem [NSSID];
   logic [NCOLS_HIM-1:0] hitMem   [1 << ADDRBITS];

   logic                 writeAccept, readAccept, hitFull, storeHit, dropHit;
   logic [CNTBITS-1:0]   curCount;
   logic                 countWe;
   logic [SSIDBITS-1:0]  countAddr;
   logic [CNTBITS-1:0]   countWData;
   logic [NCOLS_HIM-1:0] ramQ;
   logic                 readValidReg, haveDataReg, overflowReg;
   logic [CNTBITS-1:0]   readCountReg;

   always_ff @(posedge clock or negedge clearMemory) begin
      if (!clearMemory) begin
         stateReg <= CLEAR;
         sweepReg <= '0;
      end else begin
         stateReg <= stateNext;
         sweepReg <= sweepNext;
      end
   end

   // The extra sweep bit marks "all entries cleared"; READY follows one cycle later.
   always_comb begin
      stateNext = stateReg;
      sweepNext = sweepReg;
      if (stateReg == CLEAR) begin
         if (sweepReg[SSIDBITS]) stateNext = READY;
         else                    sweepNext = sweepReg + 1'b1;
      end
   end

   always_comb begin
      isReady          = (stateReg == READY);
      bus.storageReady = isReady;
      bus.readReady    = isReady;
   end

   assign writeAccept = bus.newAddress & isReady;
   assign readAccept  = bus.readRequest & isReady;
   assign curCount    = countMem[bus.SSID];
   assign hitFull     = (curCount == CNTBITS'(MAXHITS));
   assign storeHit    = writeAccept & ~hitFull;
   assign dropHit     = writeAccept & hitFull;

   // Single count write port shared by the clear sweep and hit filing.
   always_comb begin
      countWe    = storeHit;
      countAddr  = bus.SSID;
      countWData = curCount + CNTBITS'(1);
      if (stateReg == CLEAR) begin
         countWe    = ~sweepReg[SSIDBITS];
         countAddr  = sweepReg[SSIDBITS-1:0];
         countWData = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (countWe) countMem[countAddr] <= countWData;
   end

   // Read and write in one block: a same-address read returns the old word.
   always_ff @(posedge clock) begin
      if (storeHit) hitMem[{bus.SSID, curCount[IDXBITS-1:0]}] <= bus.hitInfo;
      if (readAccept) ramQ <= hitMem[{bus.readSSID, bus.readIndex}];
   end

   always_ff @(posedge clock or negedge clearMemory) begin
      if (!clearMemory) begin
         readValidReg <= 1'b0;
         haveDataReg  <= 1'b0;
         readCountReg <= '0;
         overflowReg  <= 1'b0;
      end else begin
         readValidReg <= readAccept;
         if (readAccept) begin
            haveDataReg  <= 1'b1;
            readCountReg <= countMem[bus.readSSID];
         end
         if (dropHit) overflowReg <= 1'b1;
      end
   end

`ifdef DROP_COUNTER_EN
   always_ff @(posedge clock or negedge clearMemory) begin
      if (!clearMemory)                       droppedHits <= '0;
      else if (dropHit && droppedHits != '1)  droppedHits <= droppedHits + 16'd1;
   end
`endif

   // ramQ has no reset; mask it until the first read after reset.
   assign bus.readData  = haveDataReg ? ramQ : '0;
   assign bus.readValid = readValidReg;
   assign bus.readCount = readCountReg;
   assign bus.overflow  = overflowReg;
endmodule

// File: tb/tb_block_memory_storage.sv
// Bench for block_memory_storage: vector table, hand sequences and random traffic vs. a queue/array model.
module tb_block_memory_storage;
   localparam int SB = 10, NC = 32, MH = 8, CB = 4, NS = 1 << SB;

   logic clock = 1'b0;
   logic clearMemory = 1'b0;
   always #5 clock = ~clock;

   block_memory_storage_if #(.SSIDBITS(SB), .NCOLS_HIM(NC), .MAXHITS(MH), .CNTBITS(CB)) bus ();
`ifdef DROP_COUNTER_EN
   logic [15:0] droppedHits;
`endif

   block_memory_storage #(.SSIDBITS(SB), .NCOLS_HIM(NC), .MAXHITS(MH), .CNTBITS(CB)) dut (
      .clock       (clock),
      .clearMemory (clearMemory),
      .bus         (bus)
`ifdef DROP_COUNTER_EN
      ,
      .droppedHits (droppedHits)
`endif
   );

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a hit list per SSID, capped at MH entries.
   logic [NC-1:0] modelHits [NS][$];
   bit            modelOvf;
   int            modelDrop;

   task automatic modelReset();
      for (int i = 0; i < NS; i++) modelHits[i].delete();
      modelOvf  = 0;
      modelDrop = 0;
   endtask

   task automatic modelWrite(input int s, input logic [NC-1:0] d);
      if (modelHits[s].size() < MH) modelHits[s].push_back(d);
      else begin
         modelOvf = 1;
         if (modelDrop < 65535) modelDrop++;
      end
   endtask

   // One bus cycle; expectations are taken from the model before the write lands.
   task automatic step(input bit w, input int ws, input logic [NC-1:0] wd,
                       input bit r, input int rs, input int ri,
                       output int eCnt, output logic [NC-1:0] eData, output bit eKnown);
      eCnt = 0; eData = '0; eKnown = 0;
      if (r) begin
         eCnt   = modelHits[rs].size();
         eKnown = (ri < eCnt);
         if (eKnown) eData = modelHits[rs][ri];
      end
      if (w) modelWrite(ws, wd);
      bus.newAddress  = w;
      bus.SSID        = SB'(ws);
      bus.hitInfo     = wd;
      bus.readRequest = r;
      bus.readSSID    = SB'(rs);
      bus.readIndex   = 3'(ri);
      @(posedge clock); #1;
      bus.newAddress  = 1'b0;
      bus.readRequest = 1'b0;
   endtask

   task automatic waitReady(input string name);
      int edges = 0;
      while (edges < 3000) begin
         @(posedge clock); #1;
         edges++;
         if (bus.storageReady === 1'b1) break;
      end
      bus.newAddress = 1'b0;
      chk({name, "_sweepEdges"}, 64'(edges), 64'(NS + 1));
      chk({name, "_readReady"}, 64'(bus.readReady), 64'd1);
   endtask

   typedef struct {
      bit            wr;
      int            ws;
      logic [NC-1:0] wd;
      bit            rd;
      int            rs;
      int            ri;
      int            expCnt;
      logic [NC-1:0] expData;
      bit            chkData;
   } vec_t;

   function automatic vec_t mk(bit wr, int ws, logic [NC-1:0] wd, bit rd, int rs, int ri,
                               int expCnt, logic [NC-1:0] expData, bit chkData);
      vec_t v;
      v.wr = wr; v.ws = ws; v.wd = wd; v.rd = rd; v.rs = rs; v.ri = ri;
      v.expCnt = expCnt; v.expData = expData; v.chkData = chkData;
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      int eCnt;
      logic [NC-1:0] eData;
      bit eKnown;

      tbl.push_back(mk(1, 5, 32'hA0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 5, 32'hA1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 5, 32'hA2, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 5, 0, 3, 32'hA0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 5, 1, 3, 32'hA1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 5, 2, 3, 32'hA2, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 3, 32'h33, 1, 3, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 3, 0, 1, 32'h33, 1));
      tbl.push_back(mk(1, 0, 32'h100, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, NS - 1, 32'h3FF, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h100, 1));
      tbl.push_back(mk(0, 0, 0, 1, NS - 1, 0, 1, 32'h3FF, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, NS - 2, 0, 0, 0, 0));

      bus.newAddress = 1'b0; bus.SSID = '0; bus.hitInfo = '0;
      bus.readRequest = 1'b0; bus.readSSID = '0; bus.readIndex = '0;
      modelReset();

      // Reset state, then release with newAddress held high through the sweep.
      repeat (3) @(posedge clock);
      #1;
      chk("rst_storageReady", 64'(bus.storageReady), 0);
      chk("rst_readReady", 64'(bus.readReady), 0);
      chk("rst_readValid", 64'(bus.readValid), 0);
      chk("rst_readData", 64'(bus.readData), 0);
      chk("rst_readCount", 64'(bus.readCount), 0);
      chk("rst_overflow", 64'(bus.overflow), 0);
      bus.newAddress = 1'b1; bus.SSID = '0; bus.hitInfo = 32'hDEAD;
      clearMemory = 1'b1;
      waitReady("init");

      step(0, 0, 0, 1, 0, 0, eCnt, eData, eKnown);
      chk("init_ssid0_valid", 64'(bus.readValid), 1);
      chk("init_ssid0_count", 64'(bus.readCount), 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].wr, tbl[i].ws, tbl[i].wd, tbl[i].rd, tbl[i].rs, tbl[i].ri, eCnt, eData, eKnown);
         $display("vec %0d: wr=%0d ssid=%0d data=%0h rd=%0d rssid=%0d idx=%0d -> valid=%0d count=%0d data=%0h",
                  i, tbl[i].wr, tbl[i].ws, tbl[i].wd, tbl[i].rd, tbl[i].rs, tbl[i].ri,
                  bus.readValid, bus.readCount, bus.readData);
         chk($sformatf("vec%0d_valid", i), 64'(bus.readValid), 64'(tbl[i].rd));
         if (tbl[i].rd) begin
            chk($sformatf("vec%0d_count", i), 64'(bus.readCount), 64'(tbl[i].expCnt));
            if (tbl[i].chkData) chk($sformatf("vec%0d_data", i), 64'(bus.readData), 64'(tbl[i].expData));
         end
      end
      chk("pre_ovf_overflow", 64'(bus.overflow), 0);

      // Nine writes to SSID 7: the ninth is dropped.
      for (int i = 0; i < 9; i++) step(1, 7, 32'h70 + i, 0, 0, 0, eCnt, eData, eKnown);
      step(0, 0, 0, 1, 7, 7, eCnt, eData, eKnown);
      $display("ovf: ssid7 count=%0d slot7=%0h overflow=%0d", bus.readCount, bus.readData, bus.overflow);
      chk("ovf_count", 64'(bus.readCount), 8);
      chk("ovf_slot7", 64'(bus.readData), 64'h77);
      chk("ovf_flag", 64'(bus.overflow), 1);
`ifdef DROP_COUNTER_EN
      chk("ovf_dropped", 64'(droppedHits), 1);
`endif

      // Random traffic over a small SSID set so counts saturate.
      for (int n = 0; n < 400; n++) begin
         bit w, r;
         int ws, rs, ri, pick;
         logic [NC-1:0] wd;
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         pick = $urandom_range(0, 16);
         ws = (pick == 16) ? NS - 1 : 100 + pick;
         pick = $urandom_range(0, 16);
         rs = (pick == 16) ? NS - 1 : 100 + pick;
         ri = $urandom_range(0, MH - 1);
         wd = $urandom;
         step(w, ws, wd, r, rs, ri, eCnt, eData, eKnown);
         $display("rnd %0d: wr=%0d ssid=%0d data=%0h rd=%0d rssid=%0d idx=%0d -> valid=%0d count=%0d data=%0h",
                  n, w, ws, wd, r, rs, ri, bus.readValid, bus.readCount, bus.readData);
         chk("rnd_valid", 64'(bus.readValid), 64'(r));
         if (r) begin
            chk("rnd_count", 64'(bus.readCount), 64'(eCnt));
            if (eKnown) chk("rnd_data", 64'(bus.readData), 64'(eData));
         end
         chk("rnd_overflow", 64'(bus.overflow), 64'(modelOvf));
`ifdef DROP_COUNTER_EN
         chk("rnd_dropped", 64'(droppedHits), 64'(modelDrop));
`endif
      end

      // Reset mid-stream after four writes, with a read result outstanding.
      step(1, 20, 32'h20, 0, 0, 0, eCnt, eData, eKnown);
      step(1, 21, 32'h21, 0, 0, 0, eCnt, eData, eKnown);
      step(1, 22, 32'h22, 0, 0, 0, eCnt, eData, eKnown);
      step(1, 23, 32'h23, 1, 5, 0, eCnt, eData, eKnown);
      chk("mid_pre_valid", 64'(bus.readValid), 1);
      chk("mid_pre_data", 64'(bus.readData), 64'hA0);
      #2 clearMemory = 1'b0;
      #1;
      $display("mid reset: valid=%0d data=%0h count=%0d ovf=%0d ready=%0d",
               bus.readValid, bus.readData, bus.readCount, bus.overflow, bus.storageReady);
      chk("mid_valid", 64'(bus.readValid), 0);
      chk("mid_data", 64'(bus.readData), 0);
      chk("mid_count", 64'(bus.readCount), 0);
      chk("mid_overflow", 64'(bus.overflow), 0);
      chk("mid_storageReady", 64'(bus.storageReady), 0);
`ifdef DROP_COUNTER_EN
      chk("mid_dropped", 64'(droppedHits), 0);
`endif
      modelReset();
      @(posedge clock); #1;
      clearMemory = 1'b1;
      waitReady("mid");
      for (int s = 20; s < 24; s++) begin
         step(0, 0, 0, 1, s, 0, eCnt, eData, eKnown);
         $display("post reset: ssid=%0d count=%0d", s, bus.readCount);
         chk($sformatf("post_count%0d", s), 64'(bus.readCount), 0);
      end
      step(0, 0, 0, 1, 7, 0, eCnt, eData, eKnown);
      chk("post_count7", 64'(bus.readCount), 0);
      chk("post_overflow", 64'(bus.overflow), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/block_memory_storage.md
Name: block_memory_storage

Overview:
- Per-SSID hit store. Each hit word (hitInfo) is filed into block RAM under its SSID; up to MAXHITS words are kept per SSID.
- Fed by the address counter, which drives SSID/hitInfo/newAddress and waits on storageReady.
- Provides a read port returning stored hits and per-SSID hit counts.
- After reset, sweeps and clears all per-SSID counters before accepting writes.

Parameters:
- SSIDBITS, 10, width of SSID; 2^SSIDBITS SSID entries.
- NCOLS_HIM, 32, width of one hit-info word.
- MAXHITS, 8, hits stored per SSID; must be a power of 2.
- CNTBITS, $clog2(MAXHITS)+1, width of per-SSID hit count (counts 0..MAXHITS).

Ports:
- clock  in  1  rising-edge clock, sole clock.
- clearMemory  in  1  asynchronous, active-low reset.
- newAddress  in  1  write strobe; SSID/hitInfo valid this cycle.
- SSID  in  SSIDBITS  write SSID.
- hitInfo  in  NCOLS_HIM  hit word to store.
- storageReady  out  1  high = writes accepted.
- readRequest  in  1  read strobe.
- readSSID  in  SSIDBITS  SSID to read.
- readIndex  in  $clog2(MAXHITS)  hit slot to read.
- readReady  out  1  high = read strobes accepted.
- readValid  out  1  one-cycle pulse, read result valid.
- readData  out  NCOLS_HIM  stored hit word.
- readCount  out  CNTBITS  hit count of readSSID.
- overflow  out  1  sticky; set when any hit is dropped.

Behaviour:
- Reset (clearMemory=0, asynchronous):
  - state=CLEAR, sweep pointer=0.
  - storageReady=0, readReady=0, readValid=0, readData=0, readCount=0, overflow=0.
  - RAM data contents are not cleared; only counts are.
- States are CLEAR and READY.
- CLEAR:
  - One count entry per cycle is zeroed, pointer 0..2^SSIDBITS-1.
  - After the last entry, the next cycle enters READY.
  - storageReady and readReady become 1 one cycle after the last entry is cleared: exactly 2^SSIDBITS+1 rising edges after reset release.
  - newAddress and readRequest are ignored in CLEAR.
- READY, write:
  - A write is accepted on a rising edge with newAddress=1 and storageReady=1.
  - Let c = count[SSID]. If c<MAXHITS, write hitInfo to RAM address {SSID, c[CNTBITS-2:0]} and set count[SSID]=c+1.
  - If c==MAXHITS, the hit is dropped, the count saturates and overflow is set.
  - Accept rate: one write per cycle. Back-to-back writes to the same SSID use consecutive slots; no write is lost or overwritten.
- READY, read:
  - A read is accepted on a rising edge with readRequest=1 and readReady=1.
  - Next cycle: readValid=1, readData=RAM[{readSSID, readIndex}], readCount=count[readSSID].
  - readData is undefined-but-stable when readIndex >= readCount; the bench checks readCount first.
- Simultaneous write and read to the same SSID in one cycle: read-before-write.
  - readCount returns the pre-write count.
  - The slot being written returns old data.
- readData/readCount hold their last value until the next read; readValid is low otherwise.
- storageReady stays 1 in READY; there is no backpressure beyond the clear sweep.
- readReady is 1 in READY.
- Reset mid-operation: writes and reads in flight are abandoned, readValid is forced 0, and a new sweep starts.
- SSID widths are exact; there is no wrap across SSIDs. Slot index wraps only via saturation (no wrap to slot 0).

Optional Feature:
- Macro DROP_COUNTER_EN.
- Defined:
  - Adds output droppedHits, 16 bits, reset 0.
  - Increments once per dropped hit and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port is absent and only the sticky overflow flag reports drops.

Test Plan:
- Reset release with newAddress held 1: storageReady=0 for 2^SSIDBITS edges, then 1; the count of SSID 0 read back is 0; no writes were stored.
- Writes SSID=5 with hitInfo=0xA0..0xA2 on three back-to-back cycles; read SSID 5 idx 0..2 -> readData 0xA0, 0xA1, 0xA2, readCount=3, readValid one cycle after each request.
- 9 writes to SSID 7 (MAXHITS=8): readCount=8, slot 7 holds the 8th word, overflow=1; droppedHits=1 with DROP_COUNTER_EN.
- Same-cycle write to SSID 3 (count 0) and read of SSID 3: readCount=0; a following read gives readCount=1 and the written data.
- Writes to SSID 0 and SSID 2^SSIDBITS-1: each reads back count 1 with the correct data; no cross-SSID aliasing.
- Assert clearMemory low mid-stream after 4 writes: outputs zero immediately; after the new sweep, all written SSIDs report readCount=0 and overflow=0.
